// File: rtl/cpu_fetch_align_pkg.sv
// ----------------------------------------------------------------------------
// cpu_fetch_align_pkg
// Definitions shared by the fetch/align stage and the decode stage:
//   RESET_VECTOR_DEF  default fetch address after reset
//   QUEUE_DEPTH_DEF   default halfword queue capacity
//   fetch_state_t     states of the instruction-memory request FSM
//   is_long_insn()    length predecode on the opcode high byte
// ----------------------------------------------------------------------------
package cpu_fetch_align_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_1000;
  localparam int          QUEUE_DEPTH_DEF  = 8;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_t;

  // True when the opcode carries a 32-bit immediate in the next two
  // halfwords. Form-2/3 opcodes (bit 15 set) never match and stay short.
  function automatic logic is_long_insn(input logic [7:0] op_hi);
    logic w_long;
    case (op_hi)
      8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
      8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39:
        w_long = 1'b1;
      default:
        w_long = 1'b0;
    endcase
    return w_long;
  endfunction

endpackage

// File: rtl/cpu_fetch_align_queue.sv
// ----------------------------------------------------------------------------
// fetch_halfword_queue
// Circular buffer of DEPTH x 16-bit halfwords between the instruction-memory
// interface and the issue logic. Up to two halfwords enter and 0/1/3 leave
// per cycle; the three oldest entries are always visible for assembly.
//
// Ports:
//   i_clk       clock
//   i_rst       synchronous active-high reset
//   i_clr       synchronous clear (flush), empties the queue
//   i_push_cnt  halfwords written this cycle (0..2)
//   i_push_hw0  first (lower-address) halfword written
//   i_push_hw1  second halfword, written only when i_push_cnt == 2
//   i_pop_cnt   halfwords retired this cycle (0, 1 or 3)
//   o_count     occupancy, 0..DEPTH
//   o_hw0..2    oldest three entries (undefined beyond o_count)
// ----------------------------------------------------------------------------
module fetch_halfword_queue
  import cpu_fetch_align_pkg::*;
#(
  parameter  int DEPTH = QUEUE_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic [1:0]    i_push_cnt,
  input  logic [15:0]   i_push_hw0,
  input  logic [15:0]   i_push_hw1,
  input  logic [1:0]    i_pop_cnt,
  output logic [AW:0]   o_count,
  output logic [15:0]   o_hw0,
  output logic [15:0]   o_hw1,
  output logic [15:0]   o_hw2
);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;

  logic [AW-1:0] w_wr_ptr1;
  logic [AW-1:0] w_rd_ptr1;
  logic [AW-1:0] w_rd_ptr2;

  // DEPTH is a power of two, so pointer arithmetic wraps on its own.
  always_comb begin
    w_wr_ptr1 = r_wr_ptr + AW'(1);
    w_rd_ptr1 = r_rd_ptr + AW'(1);
    w_rd_ptr2 = r_rd_ptr + AW'(2);
  end

  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      if (i_push_cnt != 2'd0) r_mem[r_wr_ptr]  <= i_push_hw0;
      if (i_push_cnt == 2'd2) r_mem[w_wr_ptr1] <= i_push_hw1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(i_push_cnt);
      r_rd_ptr <= r_rd_ptr + AW'(i_pop_cnt);
      r_count  <= r_count + (AW+1)'(i_push_cnt) - (AW+1)'(i_pop_cnt);
    end
  end

  assign o_count = r_count;
  assign o_hw0   = r_mem[r_rd_ptr];
  assign o_hw1   = r_mem[w_rd_ptr1];
  assign o_hw2   = r_mem[w_rd_ptr2];

endmodule

// File: rtl/cpu_fetch_align.sv
// ----------------------------------------------------------------------------
// cpu_fetch_align
// Instruction fetch and alignment. Requests big-endian 32-bit words, splits
// them into halfwords in fetch_halfword_queue, and issues 16-bit or 48-bit
// moxie instructions (opcode + 32-bit immediate) with their PC to decode.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   stall_i             downstream stall: outputs hold, nothing is popped
//   flush_i, newpc_i    redirect; all buffered and in-flight data discarded
//   imem_adr_o          word address of the outstanding request
//   imem_req_o          request, held until imem_ack_i
//   imem_ack_i          imem_dat_i valid this cycle
//   imem_dat_i          fetched word, [31:16] is the lower-address halfword
//   opcode_o            instruction halfword
//   operand_o           immediate of a long instruction, else 0
//   valid_o             outputs hold a real instruction
//   PC_o                address of opcode_o
//
// Request FSM:
//   state   | meaning
//   FS_IDLE | no request outstanding
//   FS_REQ  | request outstanding, returned word goes into the queue
//   FS_DROP | request outstanding across a flush, returned word is discarded
// ----------------------------------------------------------------------------
module cpu_fetch_align
  import cpu_fetch_align_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int          QUEUE_DEPTH  = QUEUE_DEPTH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] newpc_i,
  output logic [31:0] imem_adr_o,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_dat_i,
  output logic [15:0] opcode_o,
  output logic [31:0] operand_o,
  output logic        valid_o,
  output logic [31:0] PC_o
);

  localparam int          QW      = $clog2(QUEUE_DEPTH);
  localparam logic [QW:0] DEPTH_W = (QW+1)'(QUEUE_DEPTH);

  fetch_state_t r_state;
  logic         r_req;
  logic [31:0]  r_req_adr;
  logic [31:0]  r_fetch_adr;
  logic         r_drop_first;
  logic [31:0]  r_head_pc;
  logic         r_valid;
  logic [15:0]  r_opcode;
  logic [31:0]  r_operand;
  logic [31:0]  r_pc;

  logic [QW:0]  w_count;
  logic [15:0]  w_hw0;
  logic [15:0]  w_hw1;
  logic [15:0]  w_hw2;
  logic         w_ack;
  logic         w_accept;
  logic [1:0]   w_push_cnt;
  logic [15:0]  w_push_hw0;
  logic         w_head_long;
  logic         w_head_ok;
  logic         w_issue;
  logic [1:0]   w_pop_cnt;
  logic [QW:0]  w_free_after;
  logic         w_slot_free;
  logic         w_launch;
  logic [31:0]  w_fetch_nxt;

  fetch_halfword_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_clr      (flush_i),
    .i_push_cnt (w_push_cnt),
    .i_push_hw0 (w_push_hw0),
    .i_push_hw1 (imem_dat_i[15:0]),
    .i_pop_cnt  (w_pop_cnt),
    .o_count    (w_count),
    .o_hw0      (w_hw0),
    .o_hw1      (w_hw1),
    .o_hw2      (w_hw2)
  );

  always_comb begin
    // An ack with no request outstanding (e.g. one abandoned by reset) is
    // not ours and is ignored.
    w_ack    = imem_ack_i && r_req;
    w_accept = w_ack && (r_state == FS_REQ) && !flush_i;

    // After a redirect to an odd-halfword address the first word's upper
    // halfword precedes the target and is skipped.
    w_push_cnt = 2'd0;
    if (w_accept) w_push_cnt = r_drop_first ? 2'd1 : 2'd2;
    w_push_hw0 = r_drop_first ? imem_dat_i[15:0] : imem_dat_i[31:16];

    w_head_long = is_long_insn(w_hw0[15:8]);
    w_head_ok   = w_head_long ? (w_count >= (QW+1)'(3)) : (w_count >= (QW+1)'(1));
    w_issue     = !stall_i && !flush_i && w_head_ok;
    w_pop_cnt   = 2'd0;
    if (w_issue) w_pop_cnt = w_head_long ? 2'd3 : 2'd1;

    // Occupancy never exceeds DEPTH, so this cannot underflow. A new
    // request is only launched when a whole word is guaranteed to fit.
    if (flush_i) w_free_after = DEPTH_W;
    else         w_free_after = DEPTH_W - w_count - (QW+1)'(w_push_cnt) + (QW+1)'(w_pop_cnt);

    if (flush_i)       w_fetch_nxt = newpc_i & 32'hFFFF_FFFC;
    else if (w_accept) w_fetch_nxt = r_fetch_adr + 32'd4;
    else               w_fetch_nxt = r_fetch_adr;

    w_slot_free = !r_req || w_ack;
    w_launch    = w_slot_free && (w_free_after >= (QW+1)'(2));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= FS_IDLE;
      r_req        <= 1'b0;
      r_req_adr    <= RESET_VECTOR;
      r_fetch_adr  <= RESET_VECTOR;
      r_drop_first <= 1'b0;
      r_head_pc    <= RESET_VECTOR;
      r_valid      <= 1'b0;
      r_opcode     <= 16'h0000;
      r_operand    <= 32'h0000_0000;
      r_pc         <= 32'h0000_0000;
    end else begin
      r_fetch_adr <= w_fetch_nxt;

      if (w_launch) begin
        r_state   <= FS_REQ;
        r_req     <= 1'b1;
        r_req_adr <= w_fetch_nxt;
      end else if (r_req && !w_ack) begin
        // Address and request hold until the memory answers; a flush only
        // marks the answer as stale.
        if (flush_i) r_state <= FS_DROP;
      end else begin
        r_state <= FS_IDLE;
        r_req   <= 1'b0;
      end

      if (flush_i)                     r_drop_first <= newpc_i[1];
      else if (w_accept && r_drop_first) r_drop_first <= 1'b0;

      if (flush_i) begin
        r_head_pc <= newpc_i & 32'hFFFF_FFFE;
        r_valid   <= 1'b0;
      end else if (!stall_i) begin
        if (w_issue) begin
          r_head_pc <= r_head_pc + (w_head_long ? 32'd6 : 32'd2);
          r_valid   <= 1'b1;
          r_opcode  <= w_hw0;
          r_operand <= w_head_long ? {w_hw1, w_hw2} : 32'h0000_0000;
          r_pc      <= r_head_pc;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign imem_req_o = r_req;
  assign imem_adr_o = r_req_adr;
  assign valid_o    = r_valid;
  assign opcode_o   = r_opcode;
  assign operand_o  = r_operand;
  assign PC_o       = r_pc;

endmodule
